// File: rtl/gpr_exec_unit.sv
// GPR file + SGPR execute unit; mul is an iterative shift-add engine.
// Define EXEC_FLAGS_EN to build the {Z,N,C,V} flags register.
module gpr_exec_unit #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 32,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              done,
  output logic              err,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] sgpr,
  output logic [3:0]        flags
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [4:0] OP_MOVS = 5'd0;
  localparam logic [4:0] OP_MOV  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;

  typedef enum logic {IDLE, MUL} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0]   gpr_q [NUM_REGS];
  logic [DATA_W-1:0]   sgpr_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2*DATA_W-1:0] acc_q, prod;
  logic [CW-1:0]       cnt_q;
  logic [RA_W-1:0]     rd_q;
  logic                done_q, err_q;

  logic [4:0]        op;
  logic [RA_W-1:0]   rd, rs1, rs2;
  logic              mode;
  logic [DATA_W-1:0] imm, opa, opb, res;
  logic              accept, legal, is_mul, mul_last;

  always_comb begin
    op   = instr[31:27];
    rd   = instr[22 +: RA_W];
    rs1  = instr[17 +: RA_W];
    rs2  = instr[11 +: RA_W];
    mode = instr[16];
    imm  = DATA_W'(instr[15:0]);
    opa  = gpr_q[rs1];
    opb  = mode ? imm : gpr_q[rs2];
    legal  = (op <= OP_MUL);
    is_mul = (op == OP_MUL);
    res = '0;
    unique case (1'b1)
      op == OP_MOVS: res = sgpr_q;
      op == OP_MOV:  res = opb;
      op == OP_ADD:  res = opa + opb;
      op == OP_SUB:  res = opa - opb;
      default:       res = '0;
    endcase
  end

  // Partial product for the bit selected this cycle
  always_comb begin
    prod = acc_q;
    if (b_q[cnt_q])
      prod = acc_q + ({{DATA_W{1'b0}}, a_q} << cnt_q);
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = in_valid && in_ready;
    mul_last = (state_q == MUL) && (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (cnt_q == LAST)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        gpr_q[i] <= '0;
      sgpr_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        done_q <= !is_mul;
        err_q  <= !legal;
        if (is_mul) begin
          a_q   <= opa;
          b_q   <= opb;
          acc_q <= '0;
          cnt_q <= '0;
          rd_q  <= rd;
        end else if (legal) begin
          gpr_q[rd] <= res;
        end
      end
      if (state_q == MUL) begin
        acc_q <= prod;
        cnt_q <= cnt_q + CW'(1);
        if (mul_last) begin
          gpr_q[rd_q] <= prod[DATA_W-1:0];
          sgpr_q      <= prod[2*DATA_W-1:DATA_W];
          cnt_q       <= '0;
          done_q      <= 1'b1;
        end
      end
    end
  end

`ifdef EXEC_FLAGS_EN
  logic [3:0]      flags_q;
  logic [DATA_W:0] add_w;
  logic [DATA_W-1:0] sub_w;
  logic            sa, sb;

  always_comb begin
    add_w = {1'b0, opa} + {1'b0, opb};
    sub_w = opa - opb;
    sa    = opa[DATA_W-1];
    sb    = opb[DATA_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (accept && op == OP_ADD) begin
      flags_q <= {add_w[DATA_W-1:0] == '0, add_w[DATA_W-1],
                  add_w[DATA_W],
                  (sa == sb) && (add_w[DATA_W-1] != sa)};
    end else if (accept && op == OP_SUB) begin
      flags_q <= {sub_w == '0, sub_w[DATA_W-1], opa < opb,
                  (sa != sb) && (sub_w[DATA_W-1] != sa)};
    end else if (mul_last) begin
      flags_q <= {prod == '0, prod[DATA_W-1],
                  |prod[2*DATA_W-1:DATA_W], 1'b0};
    end
  end

  assign flags = flags_q;
`else
  assign flags = 4'b0000;
`endif

  assign done     = done_q;
  assign err      = err_q;
  assign sgpr     = sgpr_q;
  assign dbg_data = gpr_q[dbg_addr];

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Directed table-driven bench for gpr_exec_unit (DATA_W=16, 32 regs).
module tb_gpr_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        done;
  logic        err;
  logic [4:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] sgpr;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  gpr_exec_unit #(.DATA_W(16), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .sgpr(sgpr), .flags(flags)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] w;
    logic [4:0]  rd;
    logic [15:0] val;
    logic        er;
    logic [3:0]  fl;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [31:0] enc(input logic [4:0] op,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic m, input logic [15:0] imm);
    return {op, rd, rs1, m, imm};
  endfunction

  function automatic logic [15:0] rg(input logic [4:0] r);
    return {r, 11'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [4:0] r,
                         input logic [15:0] exp);
    dbg_addr = r;
    #1;
    chk(nm, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic chk_flg(input string nm, input logic [3:0] exp);
`ifdef EXEC_FLAGS_EN
    chk(nm, {28'h0, flags}, {28'h0, exp});
`else
    chk(nm, {28'h0, flags}, 32'h0);
`endif
  endtask

  // Issue one instruction; returns at the negedge after the accept edge
  task automatic send(input logic [31:0] w);
    @(posedge clk); #2;
    in_valid = 1'b1;
    instr    = w;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  int lowcnt;
  int dsnap;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; dbg_addr = '0;
    tbl[0]  = '{enc(5'd1, 5'd3, 5'd0, 1'b1, 16'h1234), 5'd3, 16'h1234, 1'b0, 4'b0000};
    tbl[1]  = '{enc(5'd1, 5'd1, 5'd0, 1'b1, 16'hFFFF), 5'd1, 16'hFFFF, 1'b0, 4'b0000};
    tbl[2]  = '{enc(5'd1, 5'd2, 5'd0, 1'b1, 16'h0002), 5'd2, 16'h0002, 1'b0, 4'b0000};
    tbl[3]  = '{enc(5'd2, 5'd4, 5'd1, 1'b0, rg(5'd2)),  5'd4, 16'h0001, 1'b0, 4'b0010};
    tbl[4]  = '{enc(5'd3, 5'd4, 5'd4, 1'b1, 16'h0001), 5'd4, 16'h0000, 1'b0, 4'b1000};
    tbl[5]  = '{enc(5'd3, 5'd8, 5'd2, 1'b1, 16'h0003), 5'd8, 16'hFFFF, 1'b0, 4'b0110};
    tbl[6]  = '{enc(5'd1, 5'd9, 5'd0, 1'b1, 16'h7FFF), 5'd9, 16'h7FFF, 1'b0, 4'b0110};
    tbl[7]  = '{enc(5'd2, 5'd10, 5'd9, 1'b1, 16'h0001), 5'd10, 16'h8000, 1'b0, 4'b0101};
    tbl[8]  = '{enc(5'd1, 5'd11, 5'd0, 1'b0, rg(5'd3)), 5'd11, 16'h1234, 1'b0, 4'b0101};
    tbl[9]  = '{enc(5'd31, 5'd7, 5'd1, 1'b1, 16'h5555), 5'd7, 16'h0000, 1'b1, 4'b0101};
    tbl[10] = '{enc(5'd5, 5'd3, 5'd1, 1'b1, 16'h0042), 5'd3, 16'h1234, 1'b1, 4'b0101};
    tbl[11] = '{enc(5'd0, 5'd12, 5'd0, 1'b0, 16'h0000), 5'd12, 16'h0000, 1'b0, 4'b0101};
    tbl[12] = '{enc(5'd3, 5'd15, 5'd1, 1'b0, rg(5'd1)), 5'd15, 16'h0000, 1'b0, 4'b1000};

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_sgpr", {16'h0, sgpr}, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk_reg("rst_r0", 5'd0, 16'h0);
    chk_reg("rst_r31", 5'd31, 16'h0);

    for (int i = 0; i < 13; i++) begin
      send(tbl[i].w);
      chk($sformatf("v%0d_done", i), {31'h0, done}, 32'd1);
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, tbl[i].er});
      chk_reg($sformatf("v%0d_reg", i), tbl[i].rd, tbl[i].val);
      chk_flg($sformatf("v%0d_flags", i), tbl[i].fl);
    end
    chk("illegal_sgpr", {16'h0, sgpr}, 32'h0);

    // back-to-back add then dependent sub
    @(posedge clk); #2;
    in_valid = 1'b1;
    instr = enc(5'd2, 5'd4, 5'd1, 1'b0, rg(5'd2));
    @(posedge clk); #2;
    instr = enc(5'd3, 5'd4, 5'd4, 1'b1, 16'h0001);
    @(negedge clk);
    chk("b2b_done1", {31'h0, done}, 32'd1);
    chk_reg("b2b_add", 5'd4, 16'h0001);
    chk_flg("b2b_add_flags", 4'b0010);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_done2", {31'h0, done}, 32'd1);
    chk_reg("b2b_sub", 5'd4, 16'h0000);
    chk_flg("b2b_sub_flags", 4'b1000);

    // mul with a mov held valid across the busy window
    send(enc(5'd1, 5'd1, 5'd0, 1'b1, 16'h1234));
    @(posedge clk); #2;
    in_valid = 1'b1;
    instr = enc(5'd4, 5'd5, 5'd1, 1'b1, 16'h0100);
    @(posedge clk); #2;
    instr = enc(5'd1, 5'd13, 5'd0, 1'b1, 16'hABCD);
    lowcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      lowcnt++;
    end
    chk("mul_busy_cycles", lowcnt, 16);
    chk("mul_done", {31'h0, done}, 32'd1);
    chk_reg("mul_lo", 5'd5, 16'h3400);
    chk("mul_hi", {16'h0, sgpr}, 32'h0012);
    chk_reg("held_mov_blocked", 5'd13, 16'h0000);
    chk_flg("mul_flags", 4'b0010);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_mov_done", {31'h0, done}, 32'd1);
    chk_reg("held_mov", 5'd13, 16'hABCD);
    chk("done_vs_accept", done_cnt, acc_cnt);

    send(enc(5'd0, 5'd6, 5'd0, 1'b0, 16'h0000));
    chk_reg("movsgpr", 5'd6, 16'h0012);

    // aliasing full-scale mul: r1 = r1 * r1
    send(enc(5'd1, 5'd1, 5'd0, 1'b1, 16'hFFFF));
    send(enc(5'd4, 5'd1, 5'd1, 1'b0, rg(5'd1)));
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("alias_done", {31'h0, done}, 32'd1);
    chk_reg("alias_lo", 5'd1, 16'h0001);
    chk("alias_hi", {16'h0, sgpr}, 32'h0000FFFE);
    chk_flg("alias_flags", 4'b0010);

    // reset in the middle of a multiply
    send(enc(5'd1, 5'd1, 5'd0, 1'b1, 16'hFFFF));
    send(enc(5'd4, 5'd14, 5'd1, 1'b1, 16'hFFFF));
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    dsnap = done_cnt;
    #1;
    chk("async_rst_sgpr", {16'h0, sgpr}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, dsnap);
    chk("rst_mid_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_mid_sgpr", {16'h0, sgpr}, 32'h0);
    chk("rst_mid_flags", {28'h0, flags}, 32'h0);
    chk_reg("rst_mid_r14", 5'd14, 16'h0000);
    chk_reg("rst_mid_r1", 5'd1, 16'h0000);
    chk_reg("rst_mid_r13", 5'd13, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_exec_unit.md
Name: gpr_exec_unit

Overview:
Parameterised, clocked execute unit holding the general-purpose register file and the special register SGPR.
- Accepts one 32-bit instruction per valid/ready handshake.
- Executes movsgpr, mov, add, sub and mul, with register or immediate operand mode.
- Multiply is an iterative shift-add engine that writes the full double-width product to {SGPR, GPR[rdst]}.
- Sits between instruction fetch/decode and the future memory/branch stage.

Parameters:
DATA_W, 16, width of each GPR and of SGPR (legal 8..32).
NUM_REGS, 32, number of GPRs (legal 2..32, power of two); index width RA_W = clog2(NUM_REGS).

Ports:
clk  input  1  sole clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  instruction valid.
in_ready  output  1  unit can accept an instruction; high only in IDLE.
instr  input  32  instruction word, sampled on the accept edge.
done  output  1  one-cycle pulse: an accepted instruction has completed.
err  output  1  qualified by done: the completed instruction was illegal.
dbg_addr  input  RA_W  debug read index.
dbg_data  output  DATA_W  combinational read of GPR[dbg_addr].
sgpr  output  DATA_W  current SGPR value.
flags  output  4  {Z,N,C,V}; see Optional Feature.

Behaviour:
Instruction fields:
- op[31:27], rdst[26:22], rsrc1[21:17], mode[16], rsrc2[15:11], imm[15:0].
- Only the low RA_W bits of each register field are used.
- Opcodes: movsgpr=0, mov=1, add=2, sub=3, mul=4. Opcodes 5..31 are illegal.
- Operand B is imm when mode=1, otherwise GPR[rsrc2]. imm is zero-extended to DATA_W, or truncated to its low DATA_W bits when DATA_W<16.

Reset (async assert):
- All GPRs=0, SGPR=0, state=IDLE, done=0, err=0, flags=0, multiply counter=0.
- in_ready=1 as soon as rst_n deasserts.

Handshake:
- Accept occurs on a rising edge with in_valid && in_ready.
- in_valid while in_ready=0 is ignored; there is no buffering and no stall of the sender beyond in_ready.

State machine:
- IDLE:
  - On accepting movsgpr, mov, add or sub: write GPR[rdst] on the accept edge and stay in IDLE. done=1 in the following cycle. Throughput is 1 instruction per cycle.
  - On accepting an illegal opcode: no state change. done=1 and err=1 in the following cycle.
  - On accepting mul: capture A=GPR[rsrc1] and operand B into internal registers, clear the 2*DATA_W accumulator, set cnt=0, go to MUL.
- MUL:
  - in_ready=0.
  - Each edge: if B[cnt], add A<<cnt to the accumulator; then cnt++.
  - On the edge where cnt reaches DATA_W-1, write {SGPR,GPR[rdst]} = the final product and return to IDLE.
  - done=1 in the cycle after that edge, i.e. done rises DATA_W cycles after the accept edge, and in_ready is low for exactly DATA_W cycles.

Arithmetic:
- add/sub wrap modulo 2^DATA_W.
- mul is unsigned with a 2*DATA_W-bit result: high half to SGPR, low half to GPR[rdst].
- movsgpr copies SGPR into GPR[rdst].
- Register-file writes are visible to the next accepted instruction (read-after-write through the flop, no forwarding needed).
- rdst==rsrc1 is legal. Because mul operands are captured at accept, rdst may alias a source.

Reset mid-MUL:
- Operation is abandoned; no GPR/SGPR write.
- All registers take their reset values.

dbg_data: purely combinational; it reflects a write one cycle after the write edge.

Optional Feature:
Macro EXEC_FLAGS_EN.
Defined:
- flags register updated on the completing edge of add, sub and mul only; mov, movsgpr and illegal ops leave it unchanged.
- Z: result==0, where the mul result is the full 2*DATA_W product.
- N: MSB of the written GPR.
- C: add carry-out; sub borrow (rsrc1 < B); mul: SGPR!=0.
- V: signed overflow for add/sub; 0 for mul.
Not defined: flags tied to 4'b0000 and no flag logic is synthesised.

Test Plan:
1. DATA_W=16: mov mode=1 rdst=3 imm=0x1234 -> dbg_data@3=0x1234; done pulses one cycle after accept with err=0.
2. GPR1=0xFFFF, GPR2=0x0002; add mode=0 rdst=4 rsrc1=1 rsrc2=2 -> GPR4=0x0001, flags C=1 Z=0 (with EXEC_FLAGS_EN). Back-to-back sub rdst=4 rsrc1=4 imm=1 on the next cycle -> GPR4=0x0000, Z=1, C=0.
3. GPR1=0x1234; mul mode=1 rdst=5 rsrc1=1 imm=0x0100 -> in_ready low exactly 16 cycles, GPR5=0x3400, sgpr=0x0012. Then movsgpr rdst=6 -> GPR6=0x0012.
4. in_valid held high with a mov during MUL -> not accepted, no write; accepted on the first IDLE cycle. done count equals accept count.
5. Illegal op=5'b11111 with rdst=7 -> done=1, err=1, GPR7 and SGPR unchanged.
6. rst_n low at cycle 8 of a mul 0xFFFF*0xFFFF -> GPRs=0, sgpr=0, in_ready=1 after release, no done pulse.
